mag_sqrt_seq: RTL

//   Sequential vector-magnitude unit: accepts AXES unsigned components over a valid/ready

---
 rtl/mag_calc_pkg.sv | 24 ++
 rtl/mag_isqrt_step.sv | 25 ++
 rtl/mag_sqrt_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/mag_calc_pkg.sv
// Shared types and elaboration-time helpers for the sequential vector-magnitude unit.
package mag_calc_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Radicand width: sum of AXES squares of W-bit values.
  function automatic int calc_sw(input int w, input int axes);
    return 2 * w + $clog2(axes + 1);
  endfunction

  function automatic int calc_rw(input int w, input int axes);
    return (calc_sw(w, axes) + 1) / 2;
  endfunction

  // Caller truncates to its radicand width; z only contributes for three axes.
  function automatic logic [63:0] sumsq(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z, input int axes);
    logic [63:0] acc;
    acc = 64'(x) * 64'(x) + 64'(y) * 64'(y);
    if (axes == 3) acc = acc + 64'(z) * 64'(z);
    return acc;
  endfunction

endpackage

// File: rtl/mag_isqrt_step.sv
// One restoring square-root iteration: brings down two radicand bits, resolves one root bit.
module mag_isqrt_step #(
  parameter int RW = 9
) (
  input  logic [RW+1:0] rem_i,
  input  logic [RW-1:0] root_i,
  input  logic [1:0]    bits_i,
  output logic [RW+1:0] rem_o,
  output logic [RW-1:0] root_o
);

  logic [RW+3:0] r2;
  logic [RW+1:0] t;
  logic [RW+1:0] diff;
  logic          ge;

  assign r2 = {rem_i, bits_i};
  assign t  = {root_i, 2'b01};
  assign ge = (r2 >= {2'b00, t});
  // Low bits of a modular subtraction are exact; the result fits whenever ge holds.
  assign diff   = r2[RW+1:0] - t;
  assign rem_o  = ge ? diff : r2[RW+1:0];
  assign root_o = {root_i[RW-2:0], ge};

endmodule

// File: rtl/mag_sqrt_seq.sv
// Sequential |v| = floor(sqrt(x^2+y^2(+z^2))), one result bit per clock, valid/ready on both sides.
// Define MAG_ROUND_EN to round the result to nearest (saturating) instead of flooring.
module mag_sqrt_seq
  import mag_calc_pkg::*;
#(
  parameter int W     = 8,
  parameter int AXES  = 2,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 x,
  input  logic [W-1:0]                 y,
  input  logic [W-1:0]                 z,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [calc_rw(W, AXES)-1:0]  mag,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         busy
);

  localparam int RW   = calc_rw(W, AXES);
  localparam int RADW = 2 * RW;
  localparam int CW   = $clog2(RW);

  state_e            state_q;
  logic [RADW-1:0]   rad_q;
  logic [RW+1:0]     rem_q, rem_d;
  logic [RW-1:0]     root_q, root_d;
  logic [RW-1:0]     mag_q, mag_d;
  logic [CW-1:0]     cnt_q;
  logic [TAG_W-1:0]  tag_q, out_tag_q;
  logic              in_ready_q, out_valid_q, busy_q;

  mag_isqrt_step #(.RW(RW)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[RADW-1 -: 2]),
    .rem_o  (rem_d),
    .root_o (root_d)
  );

`ifdef MAG_ROUND_EN
  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    mag_d = root_d;
    if ((rem_d > {2'b00, root_d}) && (root_d != '1)) mag_d = root_d + RW'(1);
  end
`else
  assign mag_d = root_d;
`endif

  // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: datapath registers are reset too; they are few, and it keeps mag/out_tag defined at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mag_q       <= '0;
      out_tag_q   <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            rad_q      <= RADW'(sumsq(32'(x), 32'(y), 32'(z), AXES));
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= CW'(RW - 1);
            tag_q      <= in_tag;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CALC: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          rad_q  <= rad_q << 2;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q     <= DONE;
            mag_q       <= mag_d;
            out_tag_q   <= tag_q;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign mag       = mag_q;
  assign out_tag   = out_tag_q;

endmodule
